// File: rtl/seg7_digit_monitor.sv
// Seven-segment bus monitor: debounces the segment pattern, decodes it to a digit and
// checks that accepted digits step by +1 modulo 10, counting sequence and pattern errors.
module seg7_digit_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic [6:0]       i_segments,
  output logic [3:0]       o_digit,
  output logic             o_digit_stb,
  output logic             o_seq_err,
  output logic             o_bad_pat,
  output logic             o_locked,
  output logic [ERR_W-1:0] o_err_count
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [0:0] StUnlocked = 1'b0;
  localparam logic [0:0] StLocked   = 1'b1;

  logic [6:0]       r_seg_q;
  logic [6:0]       r_last_pat;
  logic [CNT_W-1:0] r_cnt;
  logic [0:0]       r_state;
  logic [3:0]       r_digit;
  logic             r_digit_stb;
  logic             r_seq_err;
  logic             r_bad_pat;
  logic [ERR_W-1:0] r_err;

  logic [CNT_W-1:0] w_cnt_d;
  logic             w_accept;
  logic             w_dec_valid;
  logic [3:0]       w_dec_digit;
  logic [3:0]       w_exp_digit;
  logic [0:0]       w_state_d;
  logic [3:0]       w_digit_d;
  logic [6:0]       w_last_d;
  logic             w_stb_d;
  logic             w_seq_d;
  logic             w_bad_d;
  logic [ERR_W-1:0] w_err_d;

  always_comb begin
    w_dec_valid = 1'b1;
    w_dec_digit = 4'd0;
    case (r_seg_q)
      7'h3F:   w_dec_digit = 4'd0;
      7'h06:   w_dec_digit = 4'd1;
      7'h5B:   w_dec_digit = 4'd2;
      7'h4F:   w_dec_digit = 4'd3;
      7'h66:   w_dec_digit = 4'd4;
      7'h6D:   w_dec_digit = 4'd5;
      7'h7D:   w_dec_digit = 4'd6;
      7'h07:   w_dec_digit = 4'd7;
      7'h7F:   w_dec_digit = 4'd8;
      7'h6F:   w_dec_digit = 4'd9;
      default: w_dec_valid = 1'b0;
    endcase
  end

  // Counter value CNT_MAX means r_seg_q has been steady for STABLE_CYCLES samples.
  always_comb begin
    if (!i_en || i_clear || (i_segments != r_seg_q)) begin
      w_cnt_d = '0;
    end else if (r_cnt == CNT_MAX) begin
      w_cnt_d = r_cnt;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  assign w_accept    = i_en && !i_clear && (r_cnt == CNT_MAX) && (r_seg_q != r_last_pat);
  assign w_exp_digit = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;

  always_comb begin
    w_state_d = r_state;
    w_digit_d = r_digit;
    w_last_d  = r_last_pat;
    w_stb_d   = 1'b0;
    w_seq_d   = 1'b0;
    w_bad_d   = 1'b0;
    if (i_clear) begin
      w_state_d = StUnlocked;
      w_last_d  = 7'h00;
    end else if (w_accept) begin
      w_last_d = r_seg_q;
      if (w_dec_valid) begin
        w_digit_d = w_dec_digit;
        w_stb_d   = 1'b1;
        w_state_d = StLocked;
        w_seq_d   = (r_state == StLocked) && (w_dec_digit != w_exp_digit);
      end else if (r_seg_q == 7'h00) begin
        w_state_d = StUnlocked;
      end else begin
        w_bad_d   = 1'b1;
        w_state_d = StUnlocked;
      end
    end
  end

  always_comb begin
    if (i_clear) begin
      w_err_d = '0;
    end else if ((w_seq_d || w_bad_d) && (r_err != {ERR_W{1'b1}})) begin
      w_err_d = r_err + ERR_W'(1);
    end else begin
      w_err_d = r_err;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seg_q     <= 7'h00;
      r_last_pat  <= 7'h00;
      r_cnt       <= '0;
      r_state     <= StUnlocked;
      r_digit     <= 4'd0;
      r_digit_stb <= 1'b0;
      r_seq_err   <= 1'b0;
      r_bad_pat   <= 1'b0;
      r_err       <= '0;
    end else begin
      r_seg_q     <= i_segments;
      r_last_pat  <= w_last_d;
      r_cnt       <= w_cnt_d;
      r_state     <= w_state_d;
      r_digit     <= w_digit_d;
      r_digit_stb <= w_stb_d;
      r_seq_err   <= w_seq_d;
      r_bad_pat   <= w_bad_d;
      r_err       <= w_err_d;
    end
  end

  assign o_digit     = r_digit;
  assign o_digit_stb = r_digit_stb;
  assign o_seq_err   = r_seq_err;
  assign o_bad_pat   = r_bad_pat;
  assign o_locked    = (r_state == StLocked);
  assign o_err_count = r_err;

endmodule

// File: tb/tb_seg7_digit_monitor.sv
// Bench for seg7_digit_monitor: window-based reference model checked every cycle, a vector
// table of held patterns, hand-written corner sequences and a randomized phase.
module tb_seg7_digit_monitor;

  localparam int S = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [6:0] seg;

  logic [3:0] a_digit, b_digit;
  logic       a_stb, a_seq, a_bad, a_locked;
  logic       b_stb, b_seq, b_bad, b_locked;
  logic [7:0] a_err;
  logic [1:0] b_err;

  seg7_digit_monitor #(.STABLE_CYCLES(S), .ERR_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clear(clr), .i_segments(seg),
    .o_digit(a_digit), .o_digit_stb(a_stb), .o_seq_err(a_seq), .o_bad_pat(a_bad),
    .o_locked(a_locked), .o_err_count(a_err)
  );

  seg7_digit_monitor #(.STABLE_CYCLES(S), .ERR_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clear(clr), .i_segments(seg),
    .o_digit(b_digit), .o_digit_stb(b_stb), .o_seq_err(b_seq), .o_bad_pat(b_bad),
    .o_locked(b_locked), .o_err_count(b_err)
  );

  bit clk_run = 1'b0;
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int n_cmp = 0;
  int n_bad = 0;
  int t_stb, t_seq, t_bad;

  logic [6:0] pats [0:9];

  // Reference model: acceptance is judged from a window of the last S samples.
  typedef struct {logic [6:0] seg; bit en; bit clr;} smp_t;
  smp_t       hist[$];
  int         m_digit, m_raw;
  bit         m_stb, m_seq, m_bad, m_locked;
  logic [6:0] m_last;

  function automatic int decode(logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pats[i] == p) return i;
    return -1;
  endfunction

  function automatic int sat(int raw, int w);
    int mx = (1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic model_reset();
    m_digit = 0; m_raw = 0; m_stb = 0; m_seq = 0; m_bad = 0; m_locked = 0;
    m_last = 7'h00;
    hist.delete();
    hist.push_back('{7'h00, 1'b1, 1'b0});
  endtask

  task automatic model_edge();
    bit         stable;
    int         d;
    logic [6:0] p;
    p = hist[hist.size()-1].seg;
    stable = (hist.size() >= S);
    if (stable) begin
      for (int k = 0; k < S; k++) begin
        int idx = hist.size() - S + k;
        if (hist[idx].seg != p) stable = 0;
        if (k > 0 && (!hist[idx].en || hist[idx].clr)) stable = 0;
      end
    end
    m_stb = 0; m_seq = 0; m_bad = 0;
    if (clr) begin
      m_raw = 0; m_locked = 0; m_last = 7'h00;
    end else if (en && stable && p != m_last) begin
      m_last = p;
      d = decode(p);
      if (d >= 0) begin
        if (m_locked && d != (m_digit + 1) % 10) begin
          m_seq = 1; m_raw++;
        end
        m_stb = 1; m_digit = d; m_locked = 1;
      end else if (p == 7'h00) begin
        m_locked = 0;
      end else begin
        m_bad = 1; m_raw++; m_locked = 0;
      end
    end
    hist.push_back('{seg, en, clr});
    if (hist.size() > S) void'(hist.pop_front());
  endtask

  task automatic check_all(string name);
    logic [15:0] ea, ga;
    logic [9:0]  eb, gb;
    ea = {4'(m_digit), m_stb, m_seq, m_bad, m_locked, 8'(sat(m_raw, 8))};
    ga = {a_digit, a_stb, a_seq, a_bad, a_locked, a_err};
    eb = {4'(m_digit), m_stb, m_seq, m_bad, m_locked, 2'(sat(m_raw, 2))};
    gb = {b_digit, b_stb, b_seq, b_bad, b_locked, b_err};
    n_cmp++;
    if (ga !== ea) begin
      n_bad++;
      $display("FAIL %s (err8) @%0t: got {digit,stb,seq,bad,lock,err}=%h required %h",
               name, $time, ga, ea);
    end
    n_cmp++;
    if (gb !== eb) begin
      n_bad++;
      $display("FAIL %s (err2) @%0t: got {digit,stb,seq,bad,lock,err}=%h required %h",
               name, $time, gb, eb);
    end
  endtask

  task automatic expect_eq(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all("cycle");
    t_stb += int'(a_stb);
    t_seq += int'(a_seq);
    t_bad += int'(a_bad);
  endtask

  task automatic clr_tally();
    t_stb = 0; t_seq = 0; t_bad = 0;
  endtask

  typedef struct {
    logic [6:0] seg; int hold; int stb; int seq; int bad; int digit; int locked; int err;
  } vec_t;
  vec_t vt[$];

  int cur_d;

  initial begin
    pats[0] = 7'h3F; pats[1] = 7'h06; pats[2] = 7'h5B; pats[3] = 7'h4F; pats[4] = 7'h66;
    pats[5] = 7'h6D; pats[6] = 7'h7D; pats[7] = 7'h07; pats[8] = 7'h7F; pats[9] = 7'h6F;

    // Held-pattern vectors; every hold exceeds S so the acceptance lands inside its own hold.
    vt.push_back('{7'h00, 10, 0, 0, 0, 8, 0, 0});
    vt.push_back('{7'h3F, 10, 1, 0, 0, 0, 1, 0});
    for (int k = 1; k < 10; k++) vt.push_back('{pats[k], 10, 1, 0, 0, k, 1, 0});
    vt.push_back('{7'h3F, 10, 1, 0, 0, 0, 1, 0});
    vt.push_back('{7'h06,  6, 1, 0, 0, 1, 1, 0});
    vt.push_back('{7'h5B,  6, 1, 0, 0, 2, 1, 0});
    vt.push_back('{7'h4F,  6, 1, 0, 0, 3, 1, 0});
    vt.push_back('{7'h7F,  3, 0, 0, 0, 3, 1, 0});
    vt.push_back('{7'h4F,  6, 0, 0, 0, 3, 1, 0});
    vt.push_back('{7'h6D,  6, 1, 1, 0, 5, 1, 1});
    vt.push_back('{7'h7D,  6, 1, 0, 0, 6, 1, 1});
    vt.push_back('{7'h66,  6, 1, 1, 0, 4, 1, 2});
    vt.push_back('{7'h49,  6, 0, 0, 1, 4, 0, 3});
    vt.push_back('{7'h07,  6, 1, 0, 0, 7, 1, 3});
    vt.push_back('{7'h00,  6, 0, 0, 0, 7, 0, 3});

    // Reset with the clock stopped.
    rst = 1'b1; en = 1'b1; clr = 1'b0; seg = 7'h7F;
    #3;
    model_reset();
    check_all("reset_stopped_clk");
    #4 rst = 1'b0;
    #3 clk_run = 1'b1;

    clr_tally();
    repeat (S) step();
    expect_eq("no_early_stb", t_stb, 0);
    step();
    expect_eq("first_stb", int'(a_stb), 1);
    expect_eq("first_digit", int'(a_digit), 8);
    expect_eq("first_locked", int'(a_locked), 1);
    expect_eq("first_err", int'(a_err), 0);

    foreach (vt[i]) begin
      seg = vt[i].seg;
      clr_tally();
      repeat (vt[i].hold) step();
      expect_eq($sformatf("vec%0d_stb", i), t_stb, vt[i].stb);
      expect_eq($sformatf("vec%0d_seq", i), t_seq, vt[i].seq);
      expect_eq($sformatf("vec%0d_bad", i), t_bad, vt[i].bad);
      expect_eq($sformatf("vec%0d_digit", i), int'(a_digit), vt[i].digit);
      expect_eq($sformatf("vec%0d_locked", i), int'(a_locked), vt[i].locked);
      expect_eq($sformatf("vec%0d_err", i), int'(a_err), vt[i].err);
    end

    // Pattern held exactly S samples is accepted; S-1 samples is not.
    seg = 7'h7F;
    repeat (S) step();
    seg = 7'h6F;
    step();
    expect_eq("exact_s_stb", int'(a_stb), 1);
    expect_eq("exact_s_digit", int'(a_digit), 8);
    expect_eq("exact_s_seq", int'(a_seq), 0);
    clr_tally();
    repeat (6) step();
    expect_eq("after_exact_digit", int'(a_digit), 9);
    expect_eq("after_exact_seq", t_seq, 0);
    seg = 7'h3F;
    repeat (S - 1) step();
    seg = 7'h6F;
    clr_tally();
    repeat (8) step();
    expect_eq("short_hold_stb", t_stb, 0);
    expect_eq("short_hold_digit", int'(a_digit), 9);

    // Enable low freezes acceptance; counting restarts when it returns.
    en = 1'b0; seg = 7'h3F;
    clr_tally();
    repeat (8) step();
    expect_eq("en_low_stb", t_stb, 0);
    en = 1'b1;
    repeat (S - 1) step();
    expect_eq("en_restart_early", t_stb, 0);
    step();
    expect_eq("en_restart_stb", int'(a_stb), 1);
    expect_eq("wrap_digit", int'(a_digit), 0);
    expect_eq("wrap_seq", int'(a_seq), 0);

    // Clear, five bad patterns, then clear coinciding with an acceptance edge.
    clr = 1'b1; step(); clr = 1'b0;
    expect_eq("clear_err", int'(a_err), 0);
    expect_eq("clear_locked", int'(a_locked), 0);
    clr_tally();
    for (int k = 0; k < 5; k++) begin
      seg = (k % 2 == 0) ? 7'h49 : 7'h01;
      repeat (6) step();
    end
    expect_eq("bad5_count", t_bad, 5);
    expect_eq("bad5_err8", int'(a_err), 5);
    expect_eq("bad5_err2_sat", int'(b_err), 3);
    seg = 7'h06;
    repeat (S) step();
    clr = 1'b1; step(); clr = 1'b0;
    expect_eq("clr_accept_stb", int'(a_stb), 0);
    expect_eq("clr_accept_err", int'(a_err), 0);
    expect_eq("clr_accept_err2", int'(b_err), 0);
    expect_eq("clr_accept_locked", int'(a_locked), 0);
    repeat (S - 1) step();
    step();
    expect_eq("post_clr_stb", int'(a_stb), 1);
    expect_eq("post_clr_digit", int'(a_digit), 1);
    expect_eq("post_clr_seq", int'(a_seq), 0);

    // Asynchronous reset between clock edges.
    seg = 7'h5B;
    repeat (2) step();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    expect_eq("async_rst_digit", int'(a_digit), 0);
    expect_eq("async_rst_locked", int'(a_locked), 0);
    #1 rst = 1'b0;
    clr_tally();
    repeat (S) step();
    expect_eq("post_rst_early", t_stb, 0);
    step();
    expect_eq("post_rst_stb", int'(a_stb), 1);
    expect_eq("post_rst_digit", int'(a_digit), 2);
    expect_eq("post_rst_seq", int'(a_seq), 0);

    // Randomized phase, checked every cycle against the model.
    cur_d = 2;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 15) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: begin cur_d = (cur_d + 1) % 10; seg = pats[cur_d]; end
          5, 6:          begin cur_d = $urandom_range(0, 9); seg = pats[cur_d]; end
          7:             seg = 7'h00;
          default:       seg = 7'($urandom_range(0, 127));
        endcase
      end
      en  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 99) == 0);
      step();
    end
    en = 1'b1; clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_digit_monitor.md
# seg7_digit_monitor

Watches the 7-bit segment bus driven by the seven-segment seconds counter and decodes it back into digits. It filters glitches with a stability window, checks that accepted digits advance by +1 modulo 10, and counts sequence and pattern errors. It sits on the receiving end of the `uo_out[6:0]` segment interface, in the bench or on-chip as a self-check monitor.

## Interface

- `STABLE_CYCLES`, default 4: consecutive sampled cycles a pattern must hold before it is accepted; legal range 2..255.
- `ERR_W`, default 8: width of the saturating error counter.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: monitor enable. When low, the stability counter is held at 0 and the FSM holds its state.
- `clear` in 1: synchronous clear of the error count, lock state and last accepted pattern.
- `segments` in 7: segment bus, bit0 = a … bit6 = g, 1 = lit.
- `digit` out 4: last accepted digit, 0..9.
- `digit_stb` out 1: one-cycle pulse when a new digit is accepted.
- `seq_err` out 1: one-cycle pulse when an accepted digit is not the predecessor + 1 mod 10 while locked.
- `bad_pat` out 1: one-cycle pulse when a stable, non-blank, non-digit pattern is accepted.
- `locked` out 1: high when the FSM is in LOCKED.
- `err_count` out ERR_W: saturating count of `seq_err` plus `bad_pat` events.

## Operation

- **Input register.** `segments` is registered into `seg_q` every cycle, regardless of `en`.
- **Stability counter.** The counter resets to 0 when `seg_q` changes and increments while `seg_q` is unchanged. It saturates once it reaches STABLE_CYCLES-1.
- **Acceptance.** A pattern is accepted when both hold:
  - it has been in `seg_q` for STABLE_CYCLES consecutive cycles;
  - it differs from `last_pat`.
  
  Each stable run fires at most once. A glitch shorter than STABLE_CYCLES that returns to `last_pat` produces no event.
- **Decode table** (pattern → digit): 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9. 0x00 is blank. Every other pattern is invalid.
- **FSM states.** UNLOCKED (reset state) and LOCKED. On an accepted pattern:
  - **Valid digit d, in UNLOCKED:** `digit`<=d, `digit_stb`, go to LOCKED. No sequence check.
  - **Valid digit d, in LOCKED:** `digit`<=d, `digit_stb`. If d != (`digit`+1) mod 10, also pulse `seq_err` and increment `err_count`. Stay in LOCKED; the expected value resyncs to d.
  - **Blank:** go to UNLOCKED. No pulses; `digit` is unchanged.
  - **Invalid pattern:** pulse `bad_pat`, increment `err_count`, go to UNLOCKED. `digit` is unchanged.
  
  `last_pat` is updated to the accepted pattern in every case.
- **Wrap-around.** 9→0 is a legal step.
- **Error counter.** `err_count` saturates at all-ones and never wraps. `seq_err` and `bad_pat` are mutually exclusive, so the count rises by at most 1 per cycle.
- **`clear`:**
  - sets `err_count`=0, the state to UNLOCKED, `last_pat`=0x00 and the stability counter to 0;
  - suppresses any acceptance in the same cycle (clear has priority);
  - leaves `digit` unchanged.
- **`en` low:** no acceptance occurs. Pulses are 0. `seg_q` still tracks the input.

## Timing

- **Reset values:** `digit`=0, `digit_stb`=0, `seq_err`=0, `bad_pat`=0, `locked`=0, `err_count`=0, `seg_q`=0x00, `last_pat`=0x00, stability counter=0.
- **Latency.** If E0 is the first rising edge that samples a new pattern P (held steady), then `digit_stb`, `seq_err`, `bad_pat`, `digit` and `locked` take their new values after edge E0+STABLE_CYCLES. With the default this is 4 edges after E0.
- **Outputs.** All outputs are registered. Pulses last exactly one cycle.
- **`rst` mid-operation.** Asserting `rst` forces the reset values immediately, with no clock required. After deassertion, the first accepted digit is again unchecked.
- **Back-to-back patterns.** A pattern held for exactly STABLE_CYCLES edges is accepted. A pattern held for STABLE_CYCLES-1 edges is never accepted.

## Test plan

- **Reset values:** assert `rst` with the clock stopped, `segments`=0x7F → all outputs at their reset values. Release `rst` and hold 0x7F for 4 edges → `digit_stb` pulse, `digit`=8, `locked`=1, `err_count`=0.
- **Full count with wrap:** drive digits 0,1,…,9,0, each held 10 cycles → 11 `digit_stb` pulses, the final `digit`=0, `locked`=1, zero `seq_err`, `err_count`=0.
- **Glitch rejection:** hold 3 (0x4F) until accepted, drive 0x7F for 3 cycles, return to 0x4F → no further `digit_stb`. Then hold 0x7F for 4 cycles → a single `digit_stb` with `digit`=8 and `seq_err`=1.
- **Sequence skip:** …3 then 5 → `seq_err` pulse, `err_count`=1, `digit`=5. Then 6 → no `seq_err`, `err_count` stays 1.
- **Bad pattern and blank:** while locked at 4, drive 0x49 stable → `bad_pat`, `err_count`+1, `locked`=0, `digit`=4. Then 7 → `digit_stb`, no `seq_err`, `locked`=1. Then 0x00 → `locked`=0, no pulses.
- **Saturation, clear and async reset (ERR_W=2):** cause 5 errors → `err_count`=3. Pulse `clear` together with an acceptance edge → `err_count`=0, `locked`=0, no `digit_stb`. Assert `rst` mid-hold → outputs reset asynchronously.
